// File: rtl/matris_carpim_hakemi_pkg.sv
// Shared definitions for the matrix-multiplier sharing arbiter:
// sequencer state encoding, transfer sizes and a pointer helper.
package matris_carpim_hakemi_pkg;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,   // idle, waiting for a request
        AKTAR = 2'd1,   // forwarding the 16 operand words
        BEKLE = 2'd2    // waiting for the 4 result words
    } durum_t;

    // A (2x4) plus B (4x2) operand words per multiplication
    localparam int KELIME_SAYISI = 16;
    // C (2x2) result words per multiplication
    localparam int SONUC_SAYISI  = 4;

    // Priority after a release: the requester that was NOT just served.
    // Returns 1 when requester 1 should have priority next.
    function automatic logic sonraki_oncelik(input logic [1:0] biten_hak);
        return biten_hak[0];
    endfunction

endpackage

// File: rtl/matris_carpim_hakemi_rr_hakem2.sv
// Two-way round-robin one-hot arbiter. The winner is combinational;
// the priority pointer advances only when the served requester releases.
module rr_hakem2
    import matris_carpim_hakemi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] istek,
    input  logic       birak,      // one-cycle release strobe
    input  logic [1:0] birakan,    // one-hot grant being released
    output logic [1:0] secim       // one-hot winner, 0 when nobody asks
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic oncelik;

    // Pick the winner; a lone requester wins regardless of the pointer
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        secim = 2'b00;
        case (istek)
            2'b01:   secim = 2'b01;
            2'b10:   secim = 2'b10;
            2'b11:   secim = oncelik ? 2'b10 : 2'b01;
            default: secim = 2'b00;
        endcase
    end

    // Pointer moves to the other requester when a transaction finishes
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst)
            oncelik <= 1'b0;
        else if (birak)
            oncelik <= sonraki_oncelik(birakan);
    end

endmodule

// File: rtl/matris_carpim_hakemi.sv
// Shares one streaming 2x4-by-4x2 matrix multiplier between two
// requesters: grants one, forwards its 16 operand words, routes the
// 4 result words back with an element index, then re-arbitrates.
module matris_carpim_hakemi
    import matris_carpim_hakemi_pkg::*;
#(
    parameter int M = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       istek,
    input  logic [M-1:0]     istek_veri0,
    input  logic [M-1:0]     istek_veri1,
    input  logic [1:0]       istek_gecerli,
    output logic [1:0]       istek_hazir,
    output logic [1:0]       hak,
    output logic [M-1:0]     matris_veri,
    output logic             matris_gecerli,
    input  logic [2*M+1:0]   carpim_veri,
    input  logic             carpim_gecerli,
    output logic [2*M+1:0]   sonuc_veri,
    output logic [1:0]       sonuc_gecerli,
    output logic [1:0]       sonuc_indeks,
    output logic             mesgul,
    output logic [15:0]      tamamlanan
);

    durum_t       durum, durum_sonraki;
    logic [1:0]   secim;
    logic [4:0]   kelime_sayac;   // accepted operand words, 0..16
    logic [1:0]   sonuc_sayac;    // results latched so far, 0..3
    logic         kabul;          // an operand word is accepted this cycle
    logic         son_kelime;     // the 16th word is accepted this cycle
    logic         son_sonuc;      // the 4th result is latched this cycle
    logic [M-1:0] secili_veri;

    assign secili_veri = hak[1] ? istek_veri1 : istek_veri0;
    assign kabul       = |(istek_gecerli & istek_hazir);

    rr_hakem2 u_hakem (
        .clk     (clk),
        .rst     (rst),
        .istek   (istek),
        .birak   (son_sonuc),
        .birakan (hak),
        .secim   (secim)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            durum <= BOSTA;
        else
            durum <= durum_sonraki;
    end

    // Next-state: once granted, the transaction always runs to completion
    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOSTA:   if (|istek)    durum_sonraki = AKTAR;
            AKTAR:   if (son_kelime) durum_sonraki = BEKLE;
            BEKLE:   if (son_sonuc)  durum_sonraki = BOSTA;
            default: durum_sonraki = BOSTA;
        endcase
    end

    // Outputs: ready only for the granted requester until 16 words are in
    always_comb begin
        istek_hazir = 2'b00;
        mesgul      = (durum != BOSTA);
        if (durum == AKTAR && kelime_sayac < 5'(KELIME_SAYISI))
            istek_hazir = hak;
        son_kelime  = kabul && (kelime_sayac == 5'(KELIME_SAYISI - 1));
        son_sonuc   = (durum == BEKLE) && carpim_gecerli
                      && (sonuc_sayac == 2'(SONUC_SAYISI - 1));
    end

    // Grant register and operand forwarding
    always_ff @(posedge clk) begin
        if (rst) begin
            hak            <= 2'b00;
            kelime_sayac   <= 5'd0;
            matris_veri    <= '0;
            matris_gecerli <= 1'b0;
        end else begin
            matris_gecerli <= kabul;
            if (kabul) begin
                matris_veri  <= secili_veri;
                kelime_sayac <= kelime_sayac + 5'd1;
            end
            if (durum == BOSTA && |istek) begin
                hak          <= secim;
                kelime_sayac <= 5'd0;
            end else if (son_sonuc) begin
                hak <= 2'b00;
            end
        end
    end

    // Result routing; results outside BEKLE are spurious and dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            sonuc_sayac   <= 2'd0;
            sonuc_veri    <= '0;
            sonuc_gecerli <= 2'b00;
            sonuc_indeks  <= 2'd0;
            tamamlanan    <= 16'd0;
        end else begin
            sonuc_gecerli <= 2'b00;
            if (durum == BOSTA)
                sonuc_sayac <= 2'd0;
            if (durum == BEKLE && carpim_gecerli) begin
                sonuc_veri    <= carpim_veri;
                sonuc_gecerli <= hak;
                sonuc_indeks  <= sonuc_sayac;
                sonuc_sayac   <= sonuc_sayac + 2'd1;
            end
            if (son_sonuc)
                tamamlanan <= tamamlanan + 16'd1;
        end
    end

endmodule

// File: tb/tb_matris_carpim_hakemi.sv
// Bench for matris_carpim_hakemi: plays both requesters and the
// multiplier, and compares every DUT output with a matrix-level model.
module tb_matris_carpim_hakemi;

    localparam int M = 8;
    localparam int R = 2*M+2;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     istek;
    logic [M-1:0]   istek_veri0, istek_veri1;
    logic [1:0]     istek_gecerli;
    logic [1:0]     istek_hazir;
    logic [1:0]     hak;
    logic [M-1:0]   matris_veri;
    logic           matris_gecerli;
    logic [R-1:0]   carpim_veri;
    logic           carpim_gecerli;
    logic [R-1:0]   sonuc_veri;
    logic [1:0]     sonuc_gecerli;
    logic [1:0]     sonuc_indeks;
    logic           mesgul;
    logic [15:0]    tamamlanan;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: operands as sent, words seen on the multiplier side,
    // the round-robin pointer and the completion counter
    logic [7:0] op  [16];
    logic [7:0] cap [16];
    int ptr_model;
    int done_model;
    int last_sonuc;

    always #5 clk = ~clk;

    matris_carpim_hakemi #(.M(M)) dut (
        .clk            (clk),
        .rst            (rst),
        .istek          (istek),
        .istek_veri0    (istek_veri0),
        .istek_veri1    (istek_veri1),
        .istek_gecerli  (istek_gecerli),
        .istek_hazir    (istek_hazir),
        .hak            (hak),
        .matris_veri    (matris_veri),
        .matris_gecerli (matris_gecerli),
        .carpim_veri    (carpim_veri),
        .carpim_gecerli (carpim_gecerli),
        .sonuc_veri     (sonuc_veri),
        .sonuc_gecerli  (sonuc_gecerli),
        .sonuc_indeks   (sonuc_indeks),
        .mesgul         (mesgul),
        .tamamlanan     (tamamlanan)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // C[idx] of A(2x4) x B(4x2); words 0..7 are A row-major, 8..15 B row-major
    function automatic int eleman(input logic [7:0] w [16], input int idx);
        int i = idx / 2;
        int j = idx % 2;
        int s = 0;
        for (int k = 0; k < 4; k++)
            s += int'(w[i*4 + k]) * int'(w[8 + k*2 + j]);
        return s;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_hak"},            hak,            0);
        check({tag, "_hazir"},          istek_hazir,    0);
        check({tag, "_matris_gecerli"}, matris_gecerli, 0);
        check({tag, "_matris_veri"},    matris_veri,    0);
        check({tag, "_sonuc_gecerli"},  sonuc_gecerli,  0);
        check({tag, "_sonuc_veri"},     sonuc_veri,     0);
        check({tag, "_sonuc_indeks"},   sonuc_indeks,   0);
        check({tag, "_mesgul"},         mesgul,         0);
        check({tag, "_tamamlanan"},     tamamlanan,     0);
    endtask

    task automatic do_reset();
        istek_gecerli  = 2'b00;
        carpim_gecerli = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        istek = 2'b00;
        ptr_model  = 0;
        done_model = 0;
        last_sonuc = 0;
        check_all_zero("reset");
    endtask

    // One full transaction. drop_at: word count after which the served
    // requester drops istek and the other one raises it. abort_at: word
    // count after which rst is pulsed and the transaction abandoned.
    task automatic run_txn(input logic [1:0] req, input bit gaps,
                           input int drop_at, input int abort_at);
        int g;
        logic [1:0] gm;
        int k = 0;
        int budget = 0;
        bit v, acc;

        if (req == 2'b11) g = ptr_model;
        else              g = req[1] ? 1 : 0;
        gm = (g == 1) ? 2'b10 : 2'b01;

        istek = req;
        @(negedge clk);
        check("grant_hak", hak, gm);
        check("grant_mesgul", mesgul, 1);

        while (k < 16 && budget < 200) begin
            budget++;
            check("hazir_aktar", istek_hazir, gm);
            v   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = v && istek_hazir[g];
            if (g == 0) istek_veri0 = op[k];
            else        istek_veri1 = op[k];
            istek_gecerli  = v ? gm : 2'b00;
            carpim_gecerli = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            carpim_veri    = R'($urandom);
            @(negedge clk);
            check("matris_gecerli", matris_gecerli, acc);
            check("spurious_aktar", sonuc_gecerli, 0);
            check("hak_held", hak, gm);
            if (acc) begin
                check("matris_veri", matris_veri, op[k]);
                cap[k] = matris_veri;
                k++;
                if (k == drop_at) istek = ~gm;
                if (k == abort_at) begin
                    istek_gecerli  = 2'b00;
                    carpim_gecerli = 1'b0;
                    do_reset();
                    return;
                end
            end
        end
        if (k < 16) check("word_timeout", k, 16);
        istek_gecerli  = 2'b00;
        carpim_gecerli = 1'b0;
        check("hazir_bekle", istek_hazir, 0);
        check("mesgul_bekle", mesgul, 1);

        // Act as the multiplier on the words it actually received
        for (int r = 0; r < 4; r++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check("sonuc_idle", sonuc_gecerli, 0);
                    check("sonuc_tut", sonuc_veri, last_sonuc);
                end
            end
            carpim_veri    = R'(eleman(cap, r));
            carpim_gecerli = 1'b1;
            @(negedge clk);
            carpim_gecerli = 1'b0;
            last_sonuc = eleman(op, r);
            check("sonuc_gecerli", sonuc_gecerli, gm);
            check("sonuc_indeks", sonuc_indeks, r);
            check("sonuc_veri", sonuc_veri, last_sonuc);
            if (r < 3) check("hak_bekle", hak, gm);
        end
        done_model = (done_model + 1) % 65536;
        ptr_model  = 1 - g;
        check("done_hak", hak, 0);
        check("done_mesgul", mesgul, 0);
        check("tamamlanan", tamamlanan, done_model);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        istek = 2'b00;
        istek_veri0 = '0;
        istek_veri1 = '0;
        istek_gecerli = 2'b00;
        carpim_veri = '0;
        carpim_gecerli = 1'b0;
        @(negedge clk);
        do_reset();

        // Requester 0 alone, A = 1..8, B = 1..8
        for (int i = 0; i < 16; i++) op[i] = 8'(i % 8 + 1);
        run_txn(2'b01, 1'b0, -1, -1);
        istek = 2'b00;
        check("c11_known", sonuc_veri, 140);
        check("tamamlanan_first", tamamlanan, 1);

        // Spurious multiplier pulse while idle
        carpim_gecerli = 1'b1;
        carpim_veri    = R'(12345);
        @(negedge clk);
        carpim_gecerli = 1'b0;
        check("spurious_bosta_gecerli", sonuc_gecerli, 0);
        check("spurious_bosta_veri", sonuc_veri, last_sonuc);
        check("spurious_bosta_mesgul", mesgul, 0);

        // Both requesting from reset: grants alternate 0,1,0,1
        do_reset();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) op[i] = 8'($urandom);
            check("rr_order", ptr_model, t % 2);
            run_txn(2'b11, 1'b0, -1, -1);
        end
        istek = 2'b00;
        @(negedge clk);

        // Requester 1 with random gaps, all-ones operands
        for (int i = 0; i < 16; i++) op[i] = 8'hFF;
        run_txn(2'b10, 1'b1, -1, -1);
        istek = 2'b00;
        check("max_result", sonuc_veri, 260100);
        @(negedge clk);

        // Reset after 10 accepted words, then a clean transfer
        for (int i = 0; i < 16; i++) op[i] = 8'($urandom);
        run_txn(2'b01, 1'b0, -1, 10);
        @(negedge clk);
        check_all_zero("post_abort");
        for (int i = 0; i < 16; i++) op[i] = 8'($urandom);
        run_txn(2'b01, 1'b0, -1, -1);
        istek = 2'b00;
        @(negedge clk);

        // Requester 0 drops istek after 5 words while requester 1 asks
        for (int i = 0; i < 16; i++) op[i] = 8'($urandom);
        run_txn(2'b01, 1'b1, 5, -1);
        istek = 2'b00;
        @(negedge clk);
        check("idle_after_drop", hak, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
